// File: rtl/vram_fetch_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vram_fetch_arbiter_if : fetch-master strobe/ack bundle plus VRAM read port
// Rev 1.0
// ---------------------------------------------------------------------------
interface vram_fetch_arbiter_if;
    logic [14:0] l0_addr;
    logic        l0_strobe;
    logic        l0_ack;
    logic [14:0] l1_addr;
    logic        l1_strobe;
    logic        l1_ack;
    logic [14:0] spr_addr;
    logic        spr_strobe;
    logic        spr_ack;
    logic [31:0] rddata;
    logic        flush;
    logic        mem_stall;
    logic [14:0] mem_addr;
    logic        mem_rden;
    logic [31:0] mem_rddata;

    modport slave (
        input  l0_addr, l0_strobe, l1_addr, l1_strobe, spr_addr, spr_strobe,
        input  flush, mem_stall, mem_rddata,
        output l0_ack, l1_ack, spr_ack, rddata, mem_addr, mem_rden
    );

    modport master (
        output l0_addr, l0_strobe, l1_addr, l1_strobe, spr_addr, spr_strobe,
        output flush, mem_stall, mem_rddata,
        input  l0_ack, l1_ack, spr_ack, rddata, mem_addr, mem_rden
    );
endinterface
`default_nettype wire

// File: rtl/vram_fetch_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vram_fetch_arbiter : round-robin sharing of the VRAM read port among l0/l1/spr
// Rev 1.0
// ---------------------------------------------------------------------------
module vram_fetch_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    vram_fetch_arbiter_if.slave  bus
);
    localparam int         c_PIPE_DEPTH = READ_LATENCY + 1;
    localparam logic [1:0] c_ID_L0      = 2'd0;
    localparam logic [1:0] c_ID_L1      = 2'd1;
    localparam logic [1:0] c_ID_SPR     = 2'd2;

    logic [2:0]  w_strobe;
    logic [2:0]  w_elig;
    logic [1:0]  w_grant_id;
    logic [14:0] w_grant_addr;
    logic [2:0]  w_grant_oh;
    logic [2:0]  w_ret_oh;
    logic        w_issue;

    logic [1:0]              r_last;
    logic [2:0]              r_outstanding;
    logic [2:0]              r_ack;
    logic [31:0]             r_rddata;
    logic [14:0]             r_mem_addr;
    logic                    r_mem_rden;
    logic [c_PIPE_DEPTH-1:0] r_pipe_valid;
    logic [1:0]              r_pipe_id [c_PIPE_DEPTH];

    always_comb begin
        w_strobe   = {bus.spr_strobe, bus.l1_strobe, bus.l0_strobe};
        w_elig     = w_strobe & ~r_outstanding;
        w_grant_id = c_ID_L0;
        // Search starts one past the last grant and wraps modulo 3.
        case (r_last)
            c_ID_L0: begin
                if (w_elig[1])      w_grant_id = c_ID_L1;
                else if (w_elig[2]) w_grant_id = c_ID_SPR;
                else                w_grant_id = c_ID_L0;
            end
            c_ID_L1: begin
                if (w_elig[2])      w_grant_id = c_ID_SPR;
                else if (w_elig[0]) w_grant_id = c_ID_L0;
                else                w_grant_id = c_ID_L1;
            end
            default: begin
                if (w_elig[0])      w_grant_id = c_ID_L0;
                else if (w_elig[1]) w_grant_id = c_ID_L1;
                else                w_grant_id = c_ID_SPR;
            end
        endcase

        case (w_grant_id)
            c_ID_L0: w_grant_addr = bus.l0_addr;
            c_ID_L1: w_grant_addr = bus.l1_addr;
            default: w_grant_addr = bus.spr_addr;
        endcase

        w_issue    = ~bus.flush & ~bus.mem_stall & (|w_elig);
        w_grant_oh = w_issue ? (3'b001 << w_grant_id) : 3'b000;
        w_ret_oh   = r_pipe_valid[c_PIPE_DEPTH-1] ? (3'b001 << r_pipe_id[c_PIPE_DEPTH-1]) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last        <= c_ID_SPR;
            r_outstanding <= '0;
            r_ack         <= '0;
            r_rddata      <= '0;
            r_mem_addr    <= '0;
            r_mem_rden    <= 1'b0;
            r_pipe_valid  <= '0;
            for (int s = 0; s < c_PIPE_DEPTH; s++) begin
                r_pipe_id[s] <= '0;
            end
        end else begin
            r_mem_rden <= w_issue;
            if (w_issue) begin
                r_mem_addr <= w_grant_addr;
                r_last     <= w_grant_id;
            end

            // A flush drops every in-flight fetch, including one whose data is due now.
            if (bus.flush) begin
                r_pipe_valid  <= '0;
                r_outstanding <= '0;
                r_ack         <= '0;
            end else begin
                r_pipe_valid  <= {r_pipe_valid[c_PIPE_DEPTH-2:0], w_issue};
                r_ack         <= w_ret_oh;
                r_outstanding <= (r_outstanding & ~r_ack) | w_grant_oh;
                if (|w_ret_oh) begin
                    r_rddata <= bus.mem_rddata;
                end
            end

            r_pipe_id[0] <= w_grant_id;
            for (int s = 1; s < c_PIPE_DEPTH; s++) begin
                r_pipe_id[s] <= r_pipe_id[s-1];
            end
        end
    end

    assign bus.l0_ack   = r_ack[0];
    assign bus.l1_ack   = r_ack[1];
    assign bus.spr_ack  = r_ack[2];
    assign bus.rddata   = r_rddata;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_rden = r_mem_rden;

endmodule
`default_nettype wire

// File: tb/tb_vram_fetch_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vram_fetch_arbiter : directed + random stimulus against a due-time ack model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vram_fetch_arbiter;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst;

    vram_fetch_arbiter_if bus ();

    vram_fetch_arbiter #(.READ_LATENCY(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int id; logic [31:0] data; } ret_t;
    typedef struct { int due; logic [14:0] addr; } rd_t;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    ret_t        sched[$];
    rd_t         memq[$];
    bit          m_out [3];
    int          m_last;
    logic [2:0]  e_ack = 3'b000;
    logic        e_rden;
    logic [14:0] e_addr;
    logic [31:0] e_rddata;
    bit          e_rd_chk;
    bit          chk_en = 1'b0;
    bit          s_req [3];
    logic [14:0] s_addr [3];
    bit          flush_v, stall_v, rst_v, rand_ctl;
    int          p_req, p_hold, p_stall, p_flush, p_rst;
    int          ack_seen [3];
    int          ack_cnt [3];

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return {a, 2'b10, a} ^ 32'hA5C3_0F69;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check outputs, drive this cycle's inputs, predict next cycle.
    task automatic step();
        logic [2:0] dut_ack;
        logic [2:0] elig;
        logic [2:0] nack;
        int         g;
        dut_ack = {bus.spr_ack, bus.l1_ack, bus.l0_ack};
        if (chk_en) begin
            check_eq("ack", 32'(dut_ack), 32'(e_ack));
            check_eq("mem_rden", 32'(bus.mem_rden), 32'(e_rden));
            check_eq("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            if (e_rd_chk) check_eq("rddata", bus.rddata, e_rddata);
        end
        for (int i = 0; i < 3; i++) begin
            if (dut_ack[i] === 1'b1) begin
                ack_seen[i] = cyc;
                ack_cnt[i]++;
            end
        end

        if (bus.mem_rden === 1'b1) memq.push_back('{due: cyc + RL, addr: bus.mem_addr});
        bus.mem_rddata = $urandom();
        if (memq.size() > 0 && memq[0].due == cyc) begin
            bus.mem_rddata = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end

        if (rand_ctl) begin
            rst_v   = ($urandom_range(99) < p_rst);
            flush_v = ($urandom_range(99) < p_flush);
            stall_v = ($urandom_range(99) < p_stall);
        end
        for (int i = 0; i < 3; i++) begin
            if (s_req[i] && e_ack[i]) begin
                if ($urandom_range(99) >= p_hold) s_req[i] = 1'b0;
            end else if (!s_req[i] && p_req > 0 && $urandom_range(99) < p_req) begin
                s_req[i]  = 1'b1;
                s_addr[i] = 15'($urandom());
            end
        end
        bus.l0_strobe  = s_req[0];
        bus.l0_addr    = s_addr[0];
        bus.l1_strobe  = s_req[1];
        bus.l1_addr    = s_addr[1];
        bus.spr_strobe = s_req[2];
        bus.spr_addr   = s_addr[2];
        bus.flush      = flush_v;
        bus.mem_stall  = stall_v;
        rst            = rst_v;

        if (rst_v) begin
            for (int i = 0; i < 3; i++) m_out[i] = 1'b0;
            m_last   = 2;
            sched.delete();
            e_ack    = 3'b000;
            e_rden   = 1'b0;
            e_addr   = 15'h0;
            e_rddata = 32'h0;
            e_rd_chk = 1'b1;
            chk_en   = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) elig[i] = s_req[i] && !m_out[i];
            for (int i = 0; i < 3; i++) if (e_ack[i]) m_out[i] = 1'b0;
            nack     = 3'b000;
            e_rd_chk = 1'b0;
            e_rden   = 1'b0;
            if (flush_v) begin
                for (int i = 0; i < 3; i++) m_out[i] = 1'b0;
                sched.delete();
            end else begin
                if (sched.size() > 0 && sched[0].due == cyc + 1) begin
                    nack[sched[0].id] = 1'b1;
                    e_rddata = sched[0].data;
                    e_rd_chk = 1'b1;
                    void'(sched.pop_front());
                end
                if (!stall_v && elig != 3'b000) begin
                    g = -1;
                    for (int k = 1; k <= 3; k++) begin
                        if (g < 0 && elig[(m_last + k) % 3]) g = (m_last + k) % 3;
                    end
                    e_rden   = 1'b1;
                    e_addr   = s_addr[g];
                    m_out[g] = 1'b1;
                    m_last   = g;
                    sched.push_back('{due: cyc + 2 + RL, id: g, data: mem_word(s_addr[g])});
                end
            end
            e_ack = nack;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) s_req[i] = 1'b0;
        flush_v = 1'b0;
        stall_v = 1'b0;
        rst_v   = 1'b1;
        run(2);
        rst_v   = 1'b0;
    endtask

    initial begin
        int t0;
        int c0 [3];
        rand_ctl = 1'b0;
        p_req = 0; p_hold = 0; p_stall = 0; p_flush = 0; p_rst = 0;
        for (int i = 0; i < 3; i++) begin
            s_addr[i] = 15'h0; ack_seen[i] = -1; ack_cnt[i] = 0;
        end
        @(negedge clk);

        // Single request: ack exactly 2+RL cycles after the strobe.
        do_reset();
        c0 = ack_cnt;
        s_req[0] = 1'b1; s_addr[0] = 15'h0123;
        t0 = cyc;
        run(10);
        check_eq("single_lat", 32'(ack_seen[0] - t0), 32'(2 + RL));
        check_eq("single_cnt", 32'(ack_cnt[0] - c0[0]), 32'd1);

        // All three from reset: l0, l1, spr in order, acks on consecutive cycles.
        do_reset();
        c0 = ack_cnt;
        for (int i = 0; i < 3; i++) begin
            s_req[i] = 1'b1; s_addr[i] = 15'(16'h1000 + i);
        end
        t0 = cyc;
        run(10);
        for (int i = 0; i < 3; i++) begin
            check_eq("all3_lat", 32'(ack_seen[i] - t0), 32'(2 + RL + i));
            check_eq("all3_cnt", 32'(ack_cnt[i] - c0[i]), 32'd1);
        end

        // Stall for five cycles with l1 pending.
        do_reset();
        t0 = cyc;
        run(1);
        s_req[1] = 1'b1; s_addr[1] = 15'h2222; stall_v = 1'b1;
        run(5);
        stall_v = 1'b0;
        run(8);
        check_eq("stall_lat", 32'(ack_seen[1] - t0), 32'(8 + RL));

        // Flush kills the in-flight l0 fetch; the next request is served on its own data.
        do_reset();
        c0 = ack_cnt;
        s_req[0] = 1'b1; s_addr[0] = 15'h0123;
        t0 = cyc;
        run(2);
        flush_v = 1'b1; s_req[0] = 1'b0;
        run(1);
        flush_v = 1'b0; s_req[0] = 1'b1; s_addr[0] = 15'h0456;
        run(10);
        check_eq("flush_lat", 32'(ack_seen[0] - t0), 32'(5 + RL));
        check_eq("flush_cnt", 32'(ack_cnt[0] - c0[0]), 32'd1);

        // Reset with fetches in flight: no stale acks, l0 first afterwards.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_req[i] = 1'b1; s_addr[i] = 15'(16'h3000 + i);
        end
        t0 = cyc;
        run(3);
        rst_v = 1'b1;
        c0 = ack_cnt;
        run(1);
        rst_v = 1'b0;
        run(12);
        check_eq("rst_l0_lat", 32'(ack_seen[0] - t0), 32'(6 + RL));
        for (int i = 0; i < 3; i++) check_eq("rst_cnt", 32'(ack_cnt[i] - c0[i]), 32'd1);

        // Random traffic with progressively harsher control activity.
        do_reset();
        rand_ctl = 1'b1;
        p_req = 60; p_stall = 20; p_flush = 0; p_rst = 0; p_hold = 0;
        run(600);
        p_req = 30; p_stall = 10; p_flush = 3; p_rst = 0; p_hold = 20;
        run(800);
        p_req = 90; p_stall = 30; p_flush = 2; p_rst = 1; p_hold = 10;
        run(800);
        rand_ctl = 1'b0;
        p_req = 0; p_hold = 0;
        rst_v = 1'b0; flush_v = 1'b0; stall_v = 1'b0;
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
